pix_seq_ctrl: RTL and testbench

Wishbone-configured readout sequencer for the pixel macro. It drives the pixel array through reset, integrate, sample and per-pixel ADC conversion, then streams each sample to the CPU through a data register with backpressure. It sits between the Caravel Wishbone slave port and the pixel array/ADC control pins, and raises user_irq on frame completion.

---
 rtl/pix_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_pix_seq_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pix_seq_ctrl.sv
// pix_seq_ctrl: Wishbone-configured pixel readout sequencer (reset/integrate/sample, per-pixel ADC, frame IRQ).
// Define PIX_SEQ_TIMEOUT_EN to abort the frame when the ADC does not answer within TIMEOUT cycles.
module pix_seq_ctrl #(
    parameter int ROW_W   = 3,
    parameter int COL_W   = 3,
    parameter int ADC_W   = 10,
    parameter int TIMEOUT = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic [31:0]      wbs_dat_o,
    output logic             wbs_ack_o,
    output logic             pix_rst_o,
    output logic             pix_sh_o,
    output logic [ROW_W-1:0] row_sel_o,
    output logic [COL_W-1:0] col_sel_o,
    output logic             adc_start_o,
    input  logic             adc_done_i,
    input  logic [ADC_W-1:0] adc_data_i,
    output logic             irq_o
);
    typedef enum logic [2:0] {IDLE, RST, INT, SAMP, CONV, WAIT, HOLD, DONE} state_t;
    state_t state, state_nx;
    logic [31:0] timing, rdata;
    logic [15:0] lim, cnt;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [ADC_W-1:0] data;
    logic [1:0] adr;
    logic req, wr, rd, ack, ctl_wr, st_wr, cont, irq_en, start_p, abort_p;
    logic dvalid, fdone, tout, tmo, kill, cnt_done, last, busy, unused;

    assign adr = wbs_adr_i[3:2];
    assign req = wbs_cyc_i & wbs_stb_i & ~ack;
    assign wr = req & wbs_we_i;
    assign rd = req & ~wbs_we_i;
    assign ctl_wr = wr && adr == 2'd0 && wbs_sel_i[0];
    assign st_wr = wr && adr == 2'd2 && wbs_sel_i[0];
    // a programmed length of 0 behaves as 1
    assign lim = state == RST ? timing[15:0] : timing[31:16];
    assign cnt_done = lim <= 16'd1 || cnt == lim - 16'd1;
    assign last = &row && &col;
    assign busy = state != IDLE;
    assign kill = abort_p | tmo;
    assign unused = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], TIMEOUT != 0};

    assign pix_rst_o = state == RST;
    assign pix_sh_o = state == SAMP;
    assign adc_start_o = state == CONV;
    assign row_sel_o = row;
    assign col_sel_o = col;
    assign irq_o = fdone & irq_en;
    assign wbs_ack_o = ack;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (kill) state_nx = IDLE;
        else
            case (state)
                IDLE: state_nx = start_p ? RST : IDLE;
                RST:  state_nx = cnt_done ? INT : RST;
                INT:  state_nx = cnt_done ? SAMP : INT;
                SAMP: state_nx = CONV;
                CONV: state_nx = WAIT;
                WAIT: state_nx = adc_done_i ? HOLD : WAIT;
                HOLD: state_nx = dvalid ? HOLD : (last ? DONE : CONV);
                DONE: state_nx = cont ? RST : IDLE;
            endcase
    end

    always_comb begin
        rdata = '0;
        case (adr)
            2'd0: rdata[3:0] = {irq_en, 1'b0, cont, 1'b0};
            2'd1: rdata = timing;
            2'd2: begin
                rdata[6:0] = {tout, fdone, dvalid, busy, state};
                rdata[8 +: ROW_W] = row;
                rdata[16 +: COL_W] = col;
            end
            2'd3: rdata[ADC_W-1:0] = data;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack <= 1'b0;
            wbs_dat_o <= '0;
            timing <= '0;
            cont <= 1'b0;
            irq_en <= 1'b0;
            start_p <= 1'b0;
            abort_p <= 1'b0;
            cnt <= '0;
            row <= '0;
            col <= '0;
            data <= '0;
            dvalid <= 1'b0;
            fdone <= 1'b0;
        end else begin
            ack <= req;
            wbs_dat_o <= rd ? rdata : '0;
            start_p <= ctl_wr & wbs_dat_i[0];
            abort_p <= ctl_wr & wbs_dat_i[2];
            if (ctl_wr) begin
                cont <= wbs_dat_i[1];
                irq_en <= wbs_dat_i[3];
            end
            for (int i = 0; i < 4; i++)
                if (wr && adr == 2'd1 && wbs_sel_i[i]) timing[8*i +: 8] <= wbs_dat_i[8*i +: 8];
            cnt <= state_nx != state ? '0 : cnt + 16'd1;
            if (kill || state == DONE) {row, col} <= '0;
            else if (state == HOLD && !dvalid && !last) {row, col} <= {row, col} + (ROW_W+COL_W)'(1);
            if (kill) dvalid <= 1'b0;
            else if (state == WAIT && adc_done_i) begin
                dvalid <= 1'b1;
                data <= adc_data_i;
            end else if (rd && adr == 2'd3) dvalid <= 1'b0;
            fdone <= (state == DONE && !kill) | (fdone & ~(st_wr & wbs_dat_i[5]));
        end
    end

`ifdef PIX_SEQ_TIMEOUT_EN
    logic [15:0] tcnt;
    assign tmo = state == WAIT && !adc_done_i && tcnt == 16'(TIMEOUT - 1);
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tcnt <= '0;
            tout <= 1'b0;
        end else begin
            tcnt <= state == WAIT ? tcnt + 16'd1 : '0;
            tout <= tmo | (tout & ~(st_wr & wbs_dat_i[6]));
        end
    end
`else
    assign tmo = 1'b0;
    assign tout = 1'b0;
`endif
endmodule

// File: tb/tb_pix_seq_ctrl.sv
// tb_pix_seq_ctrl: randomized frame readouts of pix_seq_ctrl checked against an 8x8 pixel image model.
`timescale 1ns/1ps
module tb_pix_seq_ctrl;
    logic clk = 0, rst_n = 0, cyc = 0, stb = 0, we = 0, adc_done = 0;
    logic ack, pix_rst, pix_sh, adc_start, irq;
    logic [3:0] sel = 0;
    logic [31:0] adr = 0, wdat = 0, rdat;
    logic [2:0] row, col;
    logic [9:0] adc_data = 0;
    logic [9:0] img [64];
    int n_chk = 0, n_err = 0;

    pix_seq_ctrl dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(rdat), .wbs_ack_o(ack),
        .pix_rst_o(pix_rst), .pix_sh_o(pix_sh), .row_sel_o(row), .col_sel_o(col),
        .adc_start_o(adc_start), .adc_done_i(adc_done), .adc_data_i(adc_data), .irq_o(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running, required to finish earlier");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // called and returns at a negedge; on return the bench sits in the ack cycle
    task automatic wb(input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] q);
        int n = 0;
        cyc = 1; stb = 1; we = w; adr = {28'd0, a}; wdat = d; sel = s;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 20);
        if (!ack) chk("wb_ack_timeout", 32'(ack), 1);
        q = rdat;
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic run_frame(input int tr, input int ti, input logic ie, input logic cn, input logic rnd,
                             input int busy_px, input int rst_px);
        logic [31:0] q;
        int n, nr, ns, ni, hold;
        for (int k = 0; k < 64; k++) img[k] = rnd ? 10'($urandom) : 10'(k);
        wb(1, 4'h4, {16'(ti), 16'(tr)}, 4'hf, q);
        wb(1, 4'h0, {28'd0, ie, 1'b0, cn, 1'b1}, 4'h1, q);
        n = 0; nr = 0; ns = 0; ni = 0;
        while (!adc_start && n < 200) begin
            @(negedge clk);
            n++;
            nr += int'(pix_rst);
            ns += int'(pix_sh);
            ni += int'(!pix_rst && !pix_sh && !adc_start);
        end
        chk("first_start_latency", n, (tr > 0 ? tr : 1) + (ti > 0 ? ti : 1) + 2);
        chk("rst_cycles", nr, tr > 0 ? tr : 1);
        chk("int_cycles", ni, ti > 0 ? ti : 1);
        chk("sh_cycles", ns, 1);
        for (int i = 0; i < 64; i++) begin
            n = 0;
            while (!adc_start && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("adc_start_seen", 32'(adc_start), 1);
            chk("pix_addr", 32'({row, col}), i);
            repeat ($urandom_range(1, 4)) @(negedge clk);
            adc_done = 1;
            adc_data = img[{row, col}];
            @(negedge clk);
            adc_done = 0;
            adc_data = 10'($urandom);
            if (i == rst_px) begin
                #2 rst_n = 0;
                #1 chk("async_rst_outputs", 32'({pix_rst, pix_sh, adc_start, row, col, irq, ack}), 0);
                @(negedge clk);
                rst_n = 1;
                return;
            end
            hold = i == 0 ? 20 : $urandom_range(0, 3);
            n = 0;
            repeat (hold) begin
                @(negedge clk);
                n += int'(adc_start);
            end
            chk("no_start_in_hold", n, 0);
            if (i == busy_px) wb(1, 4'h0, {28'd0, ie, 1'b0, cn, 1'b1}, 4'h1, q);
            wb(0, 4'h8, 0, 4'hf, q);
            chk("status_hold", q, 32'(((i % 8) << 16) | ((i / 8) << 8) | 'h1E));
            wb(0, 4'hC, 0, 4'hf, q);
            chk("sample", q, 32'(img[i]));
        end
        if (cn) begin
            n = 0;
            while (!pix_rst && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("cont_restart", 32'(pix_rst), 1);
            chk("irq_cont", 32'(irq), 32'(ie));
        end else begin
            repeat (3) @(negedge clk);
            wb(0, 4'h8, 0, 4'hf, q);
            chk("status_done", q, 32'h20);
            chk("irq_done", 32'(irq), 32'(ie));
            wb(1, 4'h8, 32'h20, 4'h1, q);
            chk("irq_cleared", 32'(irq), 0);
        end
    endtask

    initial begin
        logic [31:0] q;
        int n;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rst_outputs", 32'({pix_rst, pix_sh, adc_start, row, col, irq, ack}), 0);
        wb(0, 4'h8, 0, 4'hf, q);
        chk("rst_status", q, 0);
        wb(0, 4'h4, 0, 4'hf, q);
        chk("rst_timing", q, 0);
        wb(0, 4'hC, 0, 4'hf, q);
        chk("rst_data", q, 0);
        run_frame(2, 3, 0, 0, 0, -1, -1);
        wb(0, 4'hC, 0, 4'hf, q);
        chk("data_reread", q, 32'(img[63]));
        wb(0, 4'h8, 0, 4'hf, q);
        chk("status_after_reread", q, 0);
        run_frame(0, 0, 1, 1, 1, $urandom_range(1, 62), -1);
        n = 0;
        while (!adc_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cont_frame_start", 32'(adc_start), 1);
        repeat (2) @(negedge clk);
        wb(1, 4'h0, 32'h4, 4'h1, q);
        @(negedge clk);
        chk("abort_outputs", 32'({pix_rst, pix_sh, adc_start, row, col, irq}), 0);
        wb(0, 4'h8, 0, 4'hf, q);
        chk("abort_status", q, 32'h20);
        wb(1, 4'h8, 32'h20, 4'h1, q);
        run_frame($urandom_range(0, 6), $urandom_range(0, 6), 1, 0, 1, $urandom_range(1, 62), -1);
        run_frame($urandom_range(0, 6), $urandom_range(0, 6), 1, 0, 1, -1, 10);
        wb(0, 4'h8, 0, 4'hf, q);
        chk("status_after_async_rst", q, 0);
        wb(1, 4'h4, 32'hFFFF_FFFF, 4'b0101, q);
        wb(0, 4'h4, 0, 4'hf, q);
        chk("timing_sel", q, 32'h00FF_00FF);
        wb(1, 4'h0, 32'hFFFF_FF0A, 4'h1, q);
        wb(0, 4'h0, 0, 4'hf, q);
        chk("ctrl_readback", q, 32'hA);
        wb(1, 4'h0, 32'h0, 4'h1, q);
`ifdef PIX_SEQ_TIMEOUT_EN
        wb(1, 4'h4, 32'h0001_0001, 4'hf, q);
        wb(1, 4'h0, 32'h1, 4'h1, q);
        repeat (300) @(negedge clk);
        wb(0, 4'h8, 0, 4'hf, q);
        chk("timeout_status", q, 32'h40);
        wb(1, 4'h8, 32'h40, 4'h1, q);
        wb(0, 4'h8, 0, 4'hf, q);
        chk("timeout_cleared", q, 0);
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
